// File: rtl/method_call_pkg.sv
// Shared types and helpers for the method-call driver: FSM state encoding,
// counter widths and a saturating incrementer.
package method_call_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DELAY,
      REQ,
      ACK,
      RUN,
      CAPTURE,
      DONE
   } state_t;

   localparam int unsigned DELAY_W = 16;
   localparam int unsigned WDOG_W  = 32;
   localparam int unsigned CYCLE_W = 32;

   function automatic logic [CYCLE_W-1:0] sat_inc(input logic [CYCLE_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/call_watchdog.sv
// Watchdog for an outstanding method call: counts enabled cycles since the last
// clear and flags the cycle in which the TIMEOUT-th enabled cycle completes.
module call_watchdog
   import method_call_pkg::*;
#(
   parameter int unsigned TIMEOUT = 10000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [WDOG_W-1:0] count;
   logic [WDOG_W-1:0] count_next;

   assign count_next = sat_inc(count);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count_next;
      end
   end

   // Compared against the post-increment value so the FSM leaves in the expiring cycle.
   assign expired = enable && (count_next == WDOG_W'(TIMEOUT));

endmodule

// File: rtl/method_call_driver.sv
// Deterministic caller for a Synthesijer method port: delayed request pulse, busy
// handshake under a watchdog, return capture. Optional macro METHOD_CALL_CYCLE_COUNT_EN.
module method_call_driver
   import method_call_pkg::*;
#(
   parameter int unsigned      RET_W       = 1,
   parameter logic [RET_W-1:0] EXPECT      = RET_W'(1),
   parameter int unsigned      START_DELAY = 100,
   parameter int unsigned      TIMEOUT     = 10000,
   parameter int unsigned      ACK_WAIT    = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic             callee_req,
   input  logic             callee_busy,
   input  logic [RET_W-1:0] callee_return,
   output logic             done,
   output logic             pass,
   output logic             timeout,
   output logic [RET_W-1:0] ret_value,
   output logic [31:0]      cycles
);

   localparam int unsigned ACK_CW = (ACK_WAIT < 2) ? 1 : $clog2(ACK_WAIT + 1);

   state_t              state;
   state_t              state_next;
   logic [DELAY_W-1:0]  dcnt;
   logic [DELAY_W-1:0]  dcnt_next;
   logic [ACK_CW-1:0]   ack_cnt;
   logic [ACK_CW-1:0]   ack_next;
   logic                wd_clear;
   logic                wd_enable;
   logic                wd_expired;
   logic                capture;
   logic                expire;

   call_watchdog #(
      .TIMEOUT(TIMEOUT)
   ) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .clear   (wd_clear),
      .enable  (wd_enable),
      .expired (wd_expired)
   );

   always_comb begin
      state_next = state;
      dcnt_next  = dcnt;
      ack_next   = ack_cnt;
      wd_clear   = 1'b0;
      wd_enable  = 1'b0;
      capture    = 1'b0;
      expire     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = DELAY;
               dcnt_next  = DELAY_W'(START_DELAY);
            end
         end
         DELAY: begin
            dcnt_next = (dcnt == '0) ? '0 : dcnt - 1'b1;
            if (dcnt_next == '0) begin
               state_next = REQ;
            end
         end
         REQ: begin
            wd_clear   = 1'b1;
            ack_next   = '0;
            state_next = ACK;
         end
         ACK: begin
            wd_enable = 1'b1;
            if (wd_expired) begin
               expire     = 1'b1;
               state_next = DONE;
            end else if (callee_busy) begin
               state_next = RUN;
            end else if (ack_cnt == ACK_CW'(ACK_WAIT - 1)) begin
               state_next = CAPTURE;
            end else begin
               ack_next = ack_cnt + 1'b1;
            end
         end
         RUN: begin
            wd_enable = 1'b1;
            // The busy-fall cycle is itself the capture cycle, so RUN skips the CAPTURE state.
            if (wd_expired) begin
               expire     = 1'b1;
               state_next = DONE;
            end else if (!callee_busy) begin
               capture    = 1'b1;
               state_next = DONE;
            end
         end
         CAPTURE: begin
            capture    = 1'b1;
            state_next = DONE;
         end
         DONE: begin
            if (start) begin
               state_next = DELAY;
               dcnt_next  = DELAY_W'(START_DELAY);
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         dcnt       <= '0;
         ack_cnt    <= '0;
         callee_req <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         timeout    <= 1'b0;
         ret_value  <= '0;
      end else begin
         state      <= state_next;
         dcnt       <= dcnt_next;
         ack_cnt    <= ack_next;
         callee_req <= (state_next == REQ);
         done       <= (state_next == DONE);
         if (capture) begin
            ret_value <= callee_return;
            pass      <= (callee_return == EXPECT);
            timeout   <= 1'b0;
         end else if (expire) begin
            pass    <= 1'b0;
            timeout <= 1'b1;
         end else if (state == DONE && start) begin
            pass    <= 1'b0;
            timeout <= 1'b0;
         end
      end
   end

`ifdef METHOD_CALL_CYCLE_COUNT_EN
   logic [CYCLE_W-1:0] cyc_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cyc_cnt <= '0;
      end else if (state == REQ) begin
         cyc_cnt <= '0;
      end else if (state inside {ACK, RUN, CAPTURE}) begin
         cyc_cnt <= sat_inc(cyc_cnt);
      end
   end

   assign cycles = cyc_cnt;
`else
   assign cycles = '0;
`endif

endmodule

// File: tb/tb_method_call_driver.sv
// Self-checking bench for method_call_driver: directed and randomized calls
// against an outcome model derived from the callee's busy schedule.
module tb_method_call_driver;

   localparam int unsigned RW  = 8;
   localparam logic [7:0]  EXP = 8'h5A;
   localparam int          SD  = 100;
   localparam int          TO  = 50;
   localparam int          AW  = 4;
   localparam int          NEVER = 255;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          callee_req;
   logic          callee_busy;
   logic [RW-1:0] callee_return;
   logic          done;
   logic          pass;
   logic          timeout;
   logic [RW-1:0] ret_value;
   logic [31:0]   cycles;

   int            passed = 0;
   int            total  = 0;
   logic [7:0]    ret_model = 8'h00;

   method_call_driver #(
      .RET_W       (RW),
      .EXPECT      (EXP),
      .START_DELAY (SD),
      .TIMEOUT     (TO),
      .ACK_WAIT    (AW)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .callee_req    (callee_req),
      .callee_busy   (callee_busy),
      .callee_return (callee_return),
      .done          (done),
      .pass          (pass),
      .timeout       (timeout),
      .ret_value     (ret_value),
      .cycles        (cycles)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Callee raises busy a cycles after the request for len cycles (a > AW: never acknowledges in time).
   task automatic do_call(input int a, input int len, input logic [7:0] rv,
                          input bit poke_delay, input bit poke_run);
      int off;
      int cyc_exp;
      int n;
      bit tmo_exp;
      bit got;
      if (a > AW) begin
         off = AW + 2; cyc_exp = AW + 1; tmo_exp = 1'b0;
      end else if (a + len >= TO) begin
         off = TO + 1; cyc_exp = TO; tmo_exp = 1'b1;
      end else begin
         off = a + len + 1; cyc_exp = a + len; tmo_exp = 1'b0;
      end

      callee_return = rv;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("done_clears", done, 0);
      for (int i = 1; i < SD; i++) begin
         start = poke_delay && (i == 5);
         @(negedge clk);
      end
      start = 1'b0;
      chk("req_before", callee_req, 0);
      @(negedge clk);
      chk("req_pulse", callee_req, 1);
      callee_busy = (a == 0);

      got = 1'b0;
      for (n = 1; n <= TO + 10; n++) begin
         @(negedge clk);
         start = 1'b0;
         if (n == 1) chk("req_width", callee_req, 0);
         if (done) begin
            got = 1'b1;
            break;
         end
         callee_busy = (n >= a) && (n < a + len);
         start = poke_run && (a <= AW) && (n == a + 2);
      end
      callee_busy = 1'b0;
      start = 1'b0;

      if (!tmo_exp) ret_model = rv;
      chk("done_offset", got ? 32'(n) : 32'hFFFF_FFFF, 32'(off));
      chk("timeout", timeout, tmo_exp);
      chk("pass", pass, (!tmo_exp && rv == EXP));
      chk("ret_value", ret_value, ret_model);
`ifdef METHOD_CALL_CYCLE_COUNT_EN
      chk("cycles", cycles, 32'(cyc_exp));
`else
      chk("cycles", cycles, 0);
`endif
      @(negedge clk);
      chk("done_hold", done, 1);
      chk("req_idle", callee_req, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: observed no finish expected finish");
      $fatal(1);
   end

   initial begin
      int a;
      int len;
      logic [7:0] rv;

      reset = 1'b0;
      start = 1'b0;
      callee_busy = 1'b0;
      callee_return = '0;
      repeat (3) @(negedge clk);
      chk("rst_req", callee_req, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_ret", ret_value, 0);
      chk("rst_cycles", cycles, 0);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_no_req", callee_req, 0);

      do_call(1, 20, EXP, 1'b0, 1'b0);       // normal call
      do_call(1, 20, 8'h00, 1'b0, 1'b0);     // wrong return
      do_call(1, 1000, 8'h11, 1'b0, 1'b0);   // hung callee
      do_call(NEVER, 0, EXP, 1'b0, 1'b0);    // zero-latency callee
      do_call(0, 10, EXP, 1'b1, 1'b1);       // stale busy, ignored starts
      do_call(3, TO - 3, 8'h77, 1'b0, 1'b0); // busy falls in expiry cycle
      do_call(2, TO - 3, EXP, 1'b0, 1'b1);   // falls one cycle before expiry

      // Reset while the request pulse is high.
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (SD) @(negedge clk);
      chk("rreq_pulse", callee_req, 1);
      reset = 1'b0;
      #1;
      chk("rreq_drop", callee_req, 0);
      @(negedge clk);
      reset = 1'b1;
      ret_model = 8'h00;
      @(negedge clk);

      do_call(2, 6, EXP, 1'b0, 1'b0);

      // Reset during RUN clears every output at once.
      callee_return = 8'h33;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (SD) @(negedge clk);
      callee_busy = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("mrst_req", callee_req, 0);
      chk("mrst_done", done, 0);
      chk("mrst_pass", pass, 0);
      chk("mrst_timeout", timeout, 0);
      chk("mrst_ret", ret_value, 0);
      chk("mrst_cycles", cycles, 0);
      @(negedge clk);
      callee_busy = 1'b0;
      reset = 1'b1;
      ret_model = 8'h00;
      repeat (2) @(negedge clk);
      chk("mrst_idle", callee_req, 0);

      do_call(1, 20, EXP, 1'b0, 1'b0);

      for (int k = 0; k < 16; k++) begin
         a   = $urandom_range(0, AW + 2);
         len = $urandom_range((a == 0) ? 2 : 1, 60);
         rv  = ($urandom_range(0, 1) == 1) ? EXP : 8'($urandom);
         do_call(a, len, rv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/method_call_driver.md
# method_call_driver

- Synthesizable caller stage that sits directly upstream of a Synthesijer-generated method port: it drives the `<method>_req` input and consumes the `<method>_busy` and `<method>_return` outputs.
- It replaces the free-running simulation harness counter with a deterministic sequencer that:
  - waits a programmable delay after reset;
  - issues one request pulse;
  - tracks the busy handshake under a watchdog;
  - captures the return value and reports pass/fail/timeout to on-chip status logic or a bench.

## Interface
Parameters:
- `RET_W`, 1: width of the callee return value.
- `EXPECT`, 1: expected return value, RET_W bits.
- `START_DELAY`, 100: cycles from `start` (or reset release in auto mode) to the request pulse; valid range 1..2^16-1.
- `TIMEOUT`, 10000: maximum cycles from request pulse to completion; valid range 8..2^31-1.
- `ACK_WAIT`, 4: cycles after the request pulse within which busy must rise before the callee is treated as zero-latency.

Ports:
- `clk`, in, 1: single clock; all logic on its rising edge.
- `reset`, in, 1: asynchronous, active-low reset (asserted at 0).
- `start`, in, 1: one-cycle launch pulse; ignored unless in IDLE or DONE.
- `callee_req`, out, 1: request to callee; one-cycle pulse.
- `callee_busy`, in, 1: callee busy flag.
- `callee_return`, in, RET_W: callee return value.
- `done`, out, 1: call finished (success, failure or timeout); held until next start.
- `pass`, out, 1: valid with `done`; 1 iff the captured return equals `EXPECT` and there was no timeout.
- `timeout`, out, 1: valid with `done`; watchdog expired.
- `ret_value`, out, RET_W: captured return value.
- `cycles`, out, 32: request-to-completion latency in cycles.

## Operation
- Reset (`reset` = 0) forces state IDLE and all outputs to 0, asynchronously.
- **IDLE**: `start` = 1 moves to DELAY and loads the delay counter with `START_DELAY`.
- **DELAY**:
  - Counter decrements each cycle.
  - At 0, go to REQ.
  - `start` is ignored here.
- **REQ**:
  - `callee_req` = 1 for exactly this one cycle.
  - Clear the watchdog and ack counters and the `cycles` counter.
  - Next state is ACK.
- **ACK**:
  - `callee_busy` = 1 moves to RUN.
  - If busy stays 0 for `ACK_WAIT` consecutive cycles, go to CAPTURE; this is the zero-latency callee case.
- **RUN**: `callee_busy` = 0 moves to CAPTURE.
- **Watchdog**:
  - In ACK and RUN, the watchdog increments every cycle.
  - When it reaches `TIMEOUT`, go to DONE with `timeout` = 1 and `pass` = 0.
  - `ret_value` keeps its previous value on timeout.
  - If the watchdog expiry and busy falling occur in the same cycle, timeout wins.
- **CAPTURE**:
  - `ret_value` <= `callee_return`.
  - `pass` <= (`callee_return` == `EXPECT`).
  - `timeout` <= 0.
  - Next state is DONE.
- **DONE**:
  - `done` = 1, and status outputs hold their values.
  - `start` = 1 clears `done`, `pass` and `timeout` and re-enters DELAY; repeat calls are legal.
- **`cycles`**:
  - Counts from the cycle after REQ up to and including the CAPTURE or timeout cycle.
  - Saturates at 2^32-1.
- **Reset mid-operation**: any state returns to IDLE immediately, and `callee_req` drops asynchronously.
- `callee_busy` already 1 at REQ (a callee still busy from a stale call) is treated as an acknowledgement.

## Timing
- `start` at cycle t:
  - `callee_req` is high at t+1+`START_DELAY`.
  - ACK is entered at t+2+`START_DELAY`.
- Busy falls at cycle b (sampled): CAPTURE is at b, and `done`/`pass` are visible at b+1.
- Zero-latency callee: `done` rises `ACK_WAIT`+2 cycles after the `callee_req` cycle.
- `callee_return` is sampled only in CAPTURE; the callee must hold it stable from the busy fall.
- All outputs are registered; there is no combinational path from `callee_busy` to any output.

## Configuration
- Macro `METHOD_CALL_CYCLE_COUNT_EN`:
  - Defined: the 32-bit latency counter is built and `cycles` reports latency.
  - Undefined: the counter is omitted and `cycles` is tied to 0; the watchdog is unaffected.

## Structure
- Package `method_call_pkg`:
  - State enum {IDLE, DELAY, REQ, ACK, RUN, CAPTURE, DONE}.
  - Counter width constants (delay 16, watchdog 32).
  - Saturating-increment function.
- One sub-module, `call_watchdog`:
  - Inputs: clear, enable.
  - Output: expired (count == `TIMEOUT`).
  - Parameterized by `TIMEOUT`.
- The top level holds the FSM, delay counter, capture registers and optional latency counter.

## Test plan
- **Normal call**: START_DELAY=100, callee busy high 1 cycle after req for 20 cycles, return 1 → `done`=1, `pass`=1, `timeout`=0, `ret_value`=1, `cycles`=21.
- **Wrong return**: same as normal call but return 0 → `pass`=0, `timeout`=0, `ret_value`=0.
- **Hung callee**: TIMEOUT=50, busy stuck high → `done` 51 cycles after req, `timeout`=1, `pass`=0.
- **Zero-latency callee**: busy never rises, return 1 → `done` 6 cycles after req (ACK_WAIT=4), `pass`=1.
- **Mid-run reset**: reset driven low during RUN → all outputs 0 immediately, FSM in IDLE; a subsequent start completes normally.
- **Back-to-back**: start pulsed in DONE → `done` clears next cycle, a second req pulse follows START_DELAY cycles later; `start` pulses during DELAY/RUN are ignored.
